reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter for a shared D-flip-flop register. NREQ requesters compete for write access to one WIDTH-bit register. The block grants exactly one requester per write slot, captures that requester's data into the register, and exposes q and its complement q_bar. It sits between multiple producers and the shared storage element, and sequences every write through a small FSM with a programmable post-write gap.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, register width in bits
- GAP, 1, idle cycles after each grant before the next arbitration (1..15)
- CNT_W, 16, width of the write counter

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- req  in  NREQ  level request, bit i = requester i
- wdata  in  NREQ*WIDTH  write data, requester i at wdata[i*WIDTH +: WIDTH]
- gnt  out  NREQ  registered grant, one-hot or zero
- q  out  WIDTH  shared register contents
- q_bar  out  WIDTH  always ~q
- owner  out  $clog2(NREQ)  index of the last successful writer
- valid  out  1  high once any write has completed since reset
- wr_count  out  CNT_W  completed writes, saturating

## Operation
- FSM states: IDLE, GRANT, HOLD.
- IDLE:
  - If req != 0 at the edge, select a winner, set gnt = onehot(winner) and go to GRANT.
  - Otherwise stay in IDLE with gnt = 0.
- Winner selection: the first i with req[i]=1, scanning ptr, ptr+1, …, wrapping mod NREQ.
- GRANT (exactly one cycle), at the closing edge:
  - q <= wdata slice of the winner
  - owner <= winner
  - valid <= 1
  - wr_count <= wr_count+1, saturating at all-ones
  - ptr <= (winner+1) mod NREQ
  - gnt <= 0
  - load the gap counter with GAP, go to HOLD
- req is ignored during GRANT and HOLD.
- HOLD: decrement the gap counter each cycle. Go to IDLE at the edge where it reaches 1, so HOLD lasts exactly GAP cycles.
- Requester handshake:
  - A requester holds req and wdata stable until it sees its gnt bit high.
  - It deasserts req from the cycle after gnt; GAP ≥ 1 guarantees that cycle is not sampled.
  - A requester that keeps req high is simply re-arbitrated in round-robin order.
- q_bar is combinational ~q and is never independently registered.
- Unknown or illegal FSM encodings return to IDLE.

## Timing
- Reset values, effective at the first edge with reset=1:
  - state IDLE, ptr 0, gap counter 0
  - gnt 0, q 0, q_bar all ones, owner 0, valid 0, wr_count 0
- Latency:
  - req is sampled in IDLE at edge E.
  - gnt is high in cycle E..E+1.
  - q is updated at edge E+1 and visible from cycle E+1 onward.
- Throughput: one write per 2+GAP cycles under continuous requests (3 cycles at default).
- Simultaneous requests: only one is granted per slot; the others wait for later slots in rotated order.
- ptr wrap: a grant to NREQ-1 sets ptr to 0.
- Reset mid-operation:
  - Reset high during GRANT aborts the write; q stays 0 after reset, with no counter increment.
  - Reset high during HOLD returns to IDLE.
- wr_count at all-ones stays at all-ones on further writes; the q, owner and ptr updates still occur.

## Test plan
- **Reset:** hold reset=1 for 2 cycles with req=1111. Required: gnt=0000, q=00, q_bar=FF, owner=0, valid=0, wr_count=0 throughout and in the first cycle after release.
- **Single write:** req=0001, wdata[0]=A5, drop req after gnt. Required:
  - gnt=0001 for exactly one cycle, one cycle after req is sampled.
  - Then q=A5, q_bar=5A, owner=0, valid=1, wr_count=1, with no further gnt.
- **Full contention:** req=1111 with data 11/22/33/44, each requester dropping after its grant. Required:
  - Grants in order 0,1,2,3, spaced 3 cycles apart.
  - Final q=44, owner=3, wr_count=4.
- **Round-robin wrap and fairness:** grant requester 2 alone, then assert req=1001. Required: requester 3 is granted first, then requester 0, and ptr wraps to 1.
- **Reset mid-write:** req=0100 with wdata[2]=C3, assert reset during the GRANT cycle. Required: q=00, valid=0, wr_count=0, gnt=0 after that edge; a later request from requester 0 wins, since ptr=0.
- **Parameter variants:**
  - GAP=3: consecutive grants are 5 cycles apart.
  - CNT_W=2: after 5 writes, wr_count=3, with q holding the 5th write's data.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a shared WIDTH-bit register.
// One grant per slot; each write is followed by a programmable idle gap.
module reg_write_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        q_bar,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    valid,
  output logic [CNT_W-1:0]        wr_count
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

  state_e          state_q;
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] win_q;
  logic [3:0]      gap_q;

  logic [WIDTH-1:0] slot [NREQ];
  logic [IdxW-1:0]  cand;
  logic [IdxW-1:0]  pick;
  logic             found;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot[i] = wdata[i*WIDTH +: WIDTH];
  end

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      win_q    <= '0;
      gap_q    <= '0;
      gnt      <= '0;
      q        <= '0;
      owner    <= '0;
      valid    <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            win_q   <= pick;
            gnt     <= NREQ'(1) << pick;
            state_q <= StGrant;
          end else begin
            gnt <= '0;
          end
        end
        StGrant: begin
          q     <= slot[win_q];
          owner <= win_q;
          valid <= 1'b1;
          if (wr_count != '1) begin
            wr_count <= wr_count + CNT_W'(1);
          end
          ptr_q   <= (win_q == LastIdx) ? '0 : win_q + IdxW'(1);
          gnt     <= '0;
          gap_q   <= 4'(GAP);
          state_q <= StHold;
        end
        StHold: begin
          gnt <= '0;
          if (gap_q <= 4'd1) begin
            gap_q   <= '0;
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        default: begin
          gnt     <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: slot-level behavioural model checked every cycle,
// directed scenarios with literal expectations, plus GAP=3 and CNT_W=2 instances.
module tb_reg_write_arbiter;

  localparam int GapM = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [7:0]  q, q_bar;
  logic [1:0]  owner;
  logic        valid;
  logic [15:0] wr_count;

  logic [3:0]  req_v = '0;
  logic [31:0] wdata_v = '0;
  logic [3:0]  gnt_g3, gnt_c2;
  logic [7:0]  q_g3, qb_g3, q_c2, qb_c2;
  logic [1:0]  owner_g3, owner_c2;
  logic        valid_g3, valid_c2;
  logic [15:0] cnt_g3;
  logic [1:0]  cnt_c2;

  reg_write_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt), .q(q), .q_bar(q_bar),
    .owner(owner), .valid(valid), .wr_count(wr_count)
  );

  reg_write_arbiter #(.GAP(3)) dut_g3 (
    .clk(clk), .reset(reset), .req(req_v), .wdata(wdata_v), .gnt(gnt_g3), .q(q_g3),
    .q_bar(qb_g3), .owner(owner_g3), .valid(valid_g3), .wr_count(cnt_g3)
  );

  reg_write_arbiter #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .req(req_v), .wdata(wdata_v), .gnt(gnt_c2), .q(q_c2),
    .q_bar(qb_c2), .owner(owner_c2), .valid(valid_c2), .wr_count(cnt_c2)
  );

  always #5 clk = ~clk;

  // Slot-level model: a grant opens a slot of 2+GAP edges; the write lands one edge later.
  logic [3:0]  m_gnt = '0;
  logic [7:0]  m_q = '0;
  logic [1:0]  m_owner = '0;
  logic        m_valid = 1'b0;
  logic [15:0] m_cnt = '0;
  int          m_ptr = 0, m_win = 0, m_wait = 0;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_gnt <= '0; m_q <= '0; m_owner <= '0; m_valid <= 1'b0; m_cnt <= '0;
      m_ptr <= 0; m_win <= 0; m_wait <= 0;
    end else if (m_wait != 0) begin
      if (m_wait == GapM + 1) begin
        m_q     <= wdata[m_win*8 +: 8];
        m_owner <= 2'(m_win);
        m_valid <= 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
        m_ptr   <= (m_win + 1) % 4;
        m_gnt   <= '0;
      end
      m_wait <= m_wait - 1;
    end else if (req != '0) begin
      m_win  <= rr_pick(req, m_ptr);
      m_gnt  <= 4'b0001 << rr_pick(req, m_ptr);
      m_wait <= GapM + 1;
    end
  end

  int n_vec = 0, n_bad = 0, cyc = 0, c2_grants = 0, c0;
  bit chk_en = 1'b0, auto_drop = 1'b1, vmode = 1'b0;
  int gidx[$], gcyc[$], g3idx[$], g3cyc[$];

  function automatic int qat(input int qq[$], input int i);
    if (i < qq.size()) return qq[i];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (chk_en) begin
      n_vec++;
      if ({gnt, q, q_bar, owner, valid, wr_count} !==
          {m_gnt, m_q, ~m_q, m_owner, m_valid, m_cnt}) begin
        n_bad++;
        $display("FAIL model cycle %0d: gnt %b/%b q %h/%h q_bar %h/%h owner %0d/%0d valid %b/%b cnt %0d/%0d",
                 cyc, gnt, m_gnt, q, m_q, q_bar, ~m_q, owner, m_owner, valid, m_valid,
                 wr_count, m_cnt);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin gidx.push_back(i); gcyc.push_back(cyc); end
      if (gnt_g3[i]) begin g3idx.push_back(i); g3cyc.push_back(cyc); end
    end
    if (auto_drop) req = req & ~gnt;
    if (gnt_c2 != '0) c2_grants++;
    if (vmode && c2_grants == 5) req_v = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held two cycles with every requester active.
    req = 4'b1111;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_q_bar", 32'(q_bar), 32'hFF);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_cnt", 32'(wr_count), 32'h0);
    reset = 1'b0;
    req = '0;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h0);
    chk("post_rst_valid", 32'(valid), 32'h0);

    // Single write from requester 0.
    gidx.delete(); gcyc.delete();
    wdata[7:0] = 8'hA5;
    req = 4'b0001;
    c0 = cyc;
    ticks(6);
    chk("single_ngrants", 32'(gidx.size()), 32'd1);
    chk("single_idx", 32'(qat(gidx, 0)), 32'd0);
    chk("single_latency", 32'(qat(gcyc, 0) - c0), 32'd1);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_q_bar", 32'(q_bar), 32'h5A);
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_cnt", 32'(wr_count), 32'd1);

    // Full contention after a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    gidx.delete(); gcyc.delete();
    wdata = 32'h44332211;
    req = 4'b1111;
    ticks(14);
    chk("full_ngrants", 32'(gidx.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_order%0d", i), 32'(qat(gidx, i)), 32'(i));
    end
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("full_space%0d", i), 32'(qat(gcyc, i) - qat(gcyc, i - 1)), 32'd3);
    end
    chk("full_q", 32'(q), 32'h44);
    chk("full_owner", 32'(owner), 32'd3);
    chk("full_cnt", 32'(wr_count), 32'd4);
    chk("model_pin_q", 32'(m_q), 32'h44);
    chk("model_pin_cnt", 32'(m_cnt), 32'd4);

    // Wrap: grant 2 alone, then 1001 must go 3 then 0, leaving ptr at 1.
    gidx.delete(); gcyc.delete();
    wdata = 32'h99770A0A;
    req = 4'b0100;
    ticks(4);
    req = 4'b1001;
    ticks(8);
    wdata[15:8] = 8'h5C;
    req = 4'b0011;
    ticks(8);
    chk("wrap_ngrants", 32'(gidx.size()), 32'd5);
    chk("wrap_g0", 32'(qat(gidx, 0)), 32'd2);
    chk("wrap_g1", 32'(qat(gidx, 1)), 32'd3);
    chk("wrap_g2", 32'(qat(gidx, 2)), 32'd0);
    chk("wrap_g3", 32'(qat(gidx, 3)), 32'd1);
    chk("wrap_q", 32'(q), 32'h0A);

    // Reset during GRANT aborts the write and clears ptr.
    wdata = 32'h00C300E1;
    req = 4'b0100;
    for (int i = 0; i < 8 && gnt == '0; i++) tick();
    chk("mid_gnt_seen", 32'(gnt), 32'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_q", 32'(q), 32'h0);
    chk("mid_valid", 32'(valid), 32'h0);
    chk("mid_cnt", 32'(wr_count), 32'h0);
    chk("mid_gnt", 32'(gnt), 32'h0);
    gidx.delete(); gcyc.delete();
    req = 4'b0101;
    ticks(8);
    chk("mid_after_first", 32'(qat(gidx, 0)), 32'd0);
    chk("mid_after_second", 32'(qat(gidx, 1)), 32'd2);
    chk("mid_after_q", 32'(q), 32'hC3);
    chk("mid_after_cnt", 32'(wr_count), 32'd2);

    // Parameter variants under continuous requests.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    g3idx.delete(); g3cyc.delete();
    c2_grants = 0;
    vmode = 1'b1;
    wdata_v = 32'h44332211;
    req_v = 4'b1111;
    for (int i = 0; i < 60 && c2_grants < 5; i++) tick();
    chk("c2_grants", 32'(c2_grants), 32'd5);
    ticks(3);
    chk("c2_cnt_sat", 32'(cnt_c2), 32'd3);
    chk("c2_q", 32'(q_c2), 32'h11);
    chk("c2_q_bar", 32'(qb_c2), 32'hEE);
    chk("c2_owner", 32'(owner_c2), 32'd0);
    chk("g3_first", 32'(qat(g3idx, 0)), 32'd0);
    chk("g3_second", 32'(qat(g3idx, 1)), 32'd1);
    chk("g3_space", 32'(qat(g3cyc, 1) - qat(g3cyc, 0)), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
